// File: rtl/crimson_pkg.sv
// ---------------------------------------------------------------------------
// crimson_pkg : shared widths, typedefs and FSM encoding for state_sequencer
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package crimson_pkg;

  localparam int NUM_BLOCKS = 7;
  localparam int SEL_W      = 3;
  localparam int STATE_W    = 4;

  typedef logic [STATE_W-1:0]    state_t;
  typedef logic [SEL_W-1:0]      sel_t;
  typedef logic [NUM_BLOCKS-1:0] blocks_t;
  typedef logic [SEL_W:0]        sel_ext_t;

  localparam state_t RESET_STATE = 4'h0;
  localparam sel_t   LAST_SEL    = sel_t'(NUM_BLOCKS - 1);

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_STEP = 2'd1,
    FSM_DONE = 2'd2
  } fsm_t;

endpackage

`default_nettype wire

// File: rtl/sel_scanner.sv
// ---------------------------------------------------------------------------
// sel_scanner : finds the lowest set bit of vec_i at or above index from_i
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sel_scanner
  import crimson_pkg::*;
(
  input  logic [NUM_BLOCKS-1:0] vec_i,
  input  logic [SEL_W:0]        from_i,
  output logic                  found_o,
  output logic [SEL_W-1:0]      idx_o
);

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
      if (vec_i[i] && (sel_ext_t'(i) >= from_i)) begin
        found_o = 1'b1;
        idx_o   = sel_t'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/state_sequencer.sv
// ---------------------------------------------------------------------------
// state_sequencer : owns the game state and steps a selector across the blocks
//                   word, committing next_state_in once per step.
// Optional feature: SKIP_EMPTY_EN (visit only indices whose blocks bit is set)
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module state_sequencer
  import crimson_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_BLOCKS-1:0] blocks_in,
  input  logic                  hold,
  input  logic                  clear,
  input  logic [STATE_W-1:0]    next_state_in,
  output logic [NUM_BLOCKS-1:0] blocks,
  output logic [SEL_W-1:0]      selector,
  output logic [STATE_W-1:0]    current_state,
  output logic                  busy,
  output logic                  done
);

  fsm_t    state_q, state_d;
  blocks_t blocks_q, blocks_d;
  sel_t    sel_q, sel_d;
  state_t  cs_q, cs_d;

  logic    first_found;
  sel_t    first_idx;
  logic    next_found;
  sel_t    next_idx;

`ifdef SKIP_EMPTY_EN
  sel_ext_t scan_from;
  assign scan_from = {1'b0, sel_q} + {{SEL_W{1'b0}}, 1'b1};

  sel_scanner u_first_scan (
    .vec_i   (blocks_in),
    .from_i  ('0),
    .found_o (first_found),
    .idx_o   (first_idx)
  );

  sel_scanner u_next_scan (
    .vec_i   (blocks_q),
    .from_i  (scan_from),
    .found_o (next_found),
    .idx_o   (next_idx)
  );
`else
  assign first_found = 1'b1;
  assign first_idx   = '0;
  assign next_found  = (sel_q != LAST_SEL);
  assign next_idx    = sel_q + sel_t'(1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FSM_IDLE;
      blocks_q <= '0;
      sel_q    <= '0;
      cs_q     <= RESET_STATE;
    end else begin
      state_q  <= state_d;
      blocks_q <= blocks_d;
      sel_q    <= sel_d;
      cs_q     <= cs_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    blocks_d = blocks_q;
    sel_d    = sel_q;
    cs_d     = cs_q;
    if (clear) begin
      state_d = FSM_IDLE;
      sel_d   = '0;
      cs_d    = RESET_STATE;
    end else begin
      case (state_q)
        FSM_IDLE: begin
          if (start) begin
            blocks_d = blocks_in;
            // An empty scan has nothing to commit and completes immediately.
            if (first_found) begin
              sel_d   = first_idx;
              state_d = FSM_STEP;
            end else begin
              state_d = FSM_DONE;
            end
          end
        end
        FSM_STEP: begin
          if (!hold) begin
            cs_d = next_state_in;
            if (next_found) begin
              sel_d = next_idx;
            end else begin
              state_d = FSM_DONE;
            end
          end
        end
        FSM_DONE: begin
          sel_d   = '0;
          state_d = FSM_IDLE;
        end
        default: begin
          state_d = FSM_IDLE;
        end
      endcase
    end
  end

  assign blocks        = blocks_q;
  assign selector      = sel_q;
  assign current_state = cs_q;
  assign busy          = (state_q == FSM_STEP) || (state_q == FSM_DONE);
  assign done          = (state_q == FSM_DONE);

endmodule

`default_nettype wire

// File: tb/tb_state_sequencer.sv
// ---------------------------------------------------------------------------
// tb_state_sequencer : directed and random checks against a queue-based model
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_state_sequencer;
  import crimson_pkg::*;

`ifdef SKIP_EMPTY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [NUM_BLOCKS-1:0] blocks_in;
  logic                  hold;
  logic                  clear;
  logic [STATE_W-1:0]    next_state_in;
  logic [NUM_BLOCKS-1:0] blocks;
  logic [SEL_W-1:0]      selector;
  logic [STATE_W-1:0]    current_state;
  logic                  busy;
  logic                  done;

  state_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .blocks_in     (blocks_in),
    .hold          (hold),
    .clear         (clear),
    .next_state_in (next_state_in),
    .blocks        (blocks),
    .selector      (selector),
    .current_state (current_state),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: a run is the list of indices still to visit.
  bit m_run;
  bit m_done;
  int m_q[$];
  int m_sel;
  int m_cs;
  int m_blocks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run    = 1'b0;
    m_done   = 1'b0;
    m_q.delete();
    m_sel    = 0;
    m_cs     = RESET_STATE;
    m_blocks = 0;
  endtask

  task automatic model_edge(input bit s, input int b, input bit h, input bit c, input int ns);
    if (c) begin
      m_run  = 1'b0;
      m_done = 1'b0;
      m_q.delete();
      m_sel  = 0;
      m_cs   = RESET_STATE;
    end else if (m_done) begin
      m_done = 1'b0;
      m_sel  = 0;
    end else if (m_run) begin
      if (!h) begin
        m_cs = ns;
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end else begin
          m_sel = m_q[0];
        end
      end
    end else if (s) begin
      m_blocks = b;
      for (int i = 0; i < NUM_BLOCKS; i++)
        if (!SKIP || ((b >> i) & 1) == 1) m_q.push_back(i);
      if (m_q.size() == 0) begin
        m_done = 1'b1;
      end else begin
        m_run = 1'b1;
        m_sel = m_q[0];
      end
    end
  endtask

  task automatic check_outputs();
    check("busy", busy, m_run || m_done);
    check("done", done, m_done);
    check("selector", selector, m_sel);
    check("current_state", current_state, m_cs);
    check("blocks", blocks, m_blocks);
  endtask

  // Drive at negedge, model at posedge, compare at the following negedge.
  task automatic cyc(input bit s, input int b, input bit h, input bit c, input int ns);
    start         = s;
    blocks_in     = b[NUM_BLOCKS-1:0];
    hold          = h;
    clear         = c;
    next_state_in = ns[STATE_W-1:0];
    @(posedge clk);
    model_edge(s, b & ((1 << NUM_BLOCKS) - 1), h, c, ns & ((1 << STATE_W) - 1));
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int blk, input int hold_sel, input int hold_n, output int len);
    int holds;
    bit h;
    holds = 0;
    len   = 0;
    cyc(1'b1, blk, 1'b0, 1'b0, (m_cs + 1) & 15);
    while (!done && len < 50) begin
      h = (int'(selector) == hold_sel) && (holds < hold_n);
      if (h) holds++;
      cyc(1'b0, blk, h, 1'b0, (m_cs + 1) & 15);
      len++;
    end
  endtask

  int len;

  initial begin
    rst_n = 1'b0;
    start = 1'b0; blocks_in = '0; hold = 1'b0; clear = 1'b0; next_state_in = '0;
    model_reset();

    repeat (3) begin
      @(negedge clk);
      check_outputs();
    end
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 9);
    cyc(0, 0, 1, 0, 9);

    // Full run of seven increments.
    run(7'h7F, -1, 0, len);
    check("run_len_plain", len, SKIP ? 7 : 7);
    check("cs_after_run", current_state, 7);
    cyc(0, 0, 0, 0, 3);

    // Hold three cycles at selector 2.
    run(7'h7F, 2, 3, len);
    check("run_len_hold", len, 10);
    check("cs_after_hold_run", current_state, 14);
    cyc(0, 0, 0, 0, 3);

    // Clear with simultaneous start at selector 4.
    cyc(1, 7'h7F, 0, 0, 1);
    for (int k = 0; k < 20 && selector != 3'd4; k++) cyc(0, 0, 0, 0, $urandom_range(0, 15));
    check("sel_before_clear", selector, 4);
    cyc(1, 7'h7F, 0, 1, 5);
    check("cs_after_clear", current_state, RESET_STATE);
    cyc(0, 0, 0, 0, 5);
    check("idle_after_clear", busy, 0);

    // Start during STEP is ignored, then async reset at selector 3.
    cyc(1, 7'h7F, 0, 0, 1);
    cyc(1, 7'h2A, 0, 0, 2);
    check("blocks_kept", blocks, 7'h7F);
    for (int k = 0; k < 20 && selector != 3'd3; k++) cyc(1, $urandom, 0, 0, $urandom_range(0, 15));
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_sel", selector, 0);
    check("arst_cs", current_state, RESET_STATE);
    check("arst_blocks", blocks, 0);
    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);

`ifdef SKIP_EMPTY_EN
    begin
      int seen[$];
      cyc(1, 7'b0100101, 0, 0, 1);
      for (int k = 0; k < 10 && !done; k++) begin
        seen.push_back(int'(selector));
        cyc(0, 0, 0, 0, 1);
      end
      check("skip_count", seen.size(), 3);
      if (seen.size() == 3) begin
        check("skip_sel0", seen[0], 0);
        check("skip_sel1", seen[1], 2);
        check("skip_sel2", seen[2], 5);
      end
      cyc(0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 1);
      check("skip_empty_done", done, 1);
      cyc(0, 0, 0, 0, 1);
    end
`endif

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 24) == 0), $urandom_range(0, 15));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
